// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch queue.
// INSTR_WIDTH : natural instruction word width
// NOP_INSTR   : word presented to decode when the queue is empty
// PC_STEP     : byte increment between sequential fetches
// fq_op_e     : per-cycle queue operation, {push, pop}
package fetch_pkg;

  localparam int unsigned INSTR_WIDTH = 32;
  localparam logic [INSTR_WIDTH-1:0] NOP_INSTR = 32'h00000000;
  localparam int unsigned PC_STEP = 4;

  typedef enum logic [1:0] {
    FQ_IDLE = 2'b00,
    FQ_POP  = 2'b01,
    FQ_PUSH = 2'b10,
    FQ_BOTH = 2'b11
  } fq_op_e;

endpackage

// File: rtl/fetch_queue_ptr.sv
// Wrap-around pointer register for the fetch queue.
// clk_i   : rising-edge clock
// rst_i   : asynchronous active-high reset, pointer -> 0
// clear_i : synchronous clear, has priority over inc_i
// inc_i   : advance pointer by one, wrapping modulo DEPTH
// ptr_o   : current pointer value
module fetch_queue_ptr #(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned PW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          clear_i,
  input  logic          inc_i,
  output logic [PW-1:0] ptr_o
);

  logic [PW-1:0] ptr_q, ptr_d;

  // DEPTH is a power of two, so natural overflow gives the modulo wrap.
  always_comb begin
    ptr_d = ptr_q;
    if (clear_i) begin
      ptr_d = '0;
    end else if (inc_i) begin
      ptr_d = ptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/fetch_queue.sv
// Decoupling queue between instruction fetch and decode.
// Clk            : rising-edge clock
// Reset          : asynchronous active-high, empties the queue
// Flush          : synchronous discard of all entries (beats push/pop)
// InValid/InReady: fetch-side handshake; InReady = not full
// InPC/InInstruction : entry presented by fetch
// OutValid/OutReady  : decode-side handshake; OutValid = not empty
// OutPC/OutInstruction : head entry, zero (NOP) when empty
// Count          : number of occupied entries
module fetch_queue
  import fetch_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  parameter  int unsigned WIDTH = 32,
  localparam int unsigned PW    = $clog2(DEPTH),
  localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Flush,
  input  logic             InValid,
  output logic             InReady,
  input  logic [WIDTH-1:0] InPC,
  input  logic [WIDTH-1:0] InInstruction,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [WIDTH-1:0] OutPC,
  output logic [WIDTH-1:0] OutInstruction,
  output logic [CW-1:0]    Count
);

  logic [WIDTH-1:0] pc_q    [DEPTH];
  logic [WIDTH-1:0] instr_q [DEPTH];

  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count_q, count_d;
  logic          push, pop;
  fq_op_e        op;

  // Ready/valid come only from the registered count, so a pop in a full
  // cycle never opens the door for a push in that same cycle.
  assign InReady  = (count_q != CW'(DEPTH));
  assign OutValid = (count_q != '0);
  assign Count    = count_q;

  assign push = InValid && InReady && !Flush;
  assign pop  = OutValid && OutReady && !Flush;
  assign op   = fq_op_e'({push, pop});

  fetch_queue_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
    .clk_i   (Clk),
    .rst_i   (Reset),
    .clear_i (Flush),
    .inc_i   (push),
    .ptr_o   (wr_ptr)
  );

  fetch_queue_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
    .clk_i   (Clk),
    .rst_i   (Reset),
    .clear_i (Flush),
    .inc_i   (pop),
    .ptr_o   (rd_ptr)
  );

  always_comb begin
    count_d = count_q;
    if (Flush) begin
      count_d = '0;
    end else begin
      unique case (op)
        FQ_PUSH: count_d = count_q + CW'(1);
        FQ_POP:  count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Storage is not reset; the empty-masking below hides stale contents.
  always_ff @(posedge Clk) begin
    if (push) begin
      pc_q[wr_ptr]    <= InPC;
      instr_q[wr_ptr] <= InInstruction;
    end
  end

  assign OutPC          = OutValid ? pc_q[rd_ptr]    : '0;
  assign OutInstruction = OutValid ? instr_q[rd_ptr] : WIDTH'(NOP_INSTR);

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;
  import fetch_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned WIDTH = 32;
  localparam int unsigned CW    = $clog2(DEPTH + 1);

  logic             Clk = 1'b0;
  logic             Reset = 1'b1;
  logic             Flush = 1'b0;
  logic             InValid = 1'b0;
  logic             InReady;
  logic [WIDTH-1:0] InPC = '0;
  logic [WIDTH-1:0] InInstruction = '0;
  logic             OutValid;
  logic             OutReady = 1'b0;
  logic [WIDTH-1:0] OutPC;
  logic [WIDTH-1:0] OutInstruction;
  logic [CW-1:0]    Count;

  int checks = 0;
  int errors = 0;

  // Reference model: an ordered list of {pc, instr} entries.
  logic [2*WIDTH-1:0] mq[$];
  bit last_push;
  bit last_flush;

  fetch_queue #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .Clk            (Clk),
    .Reset          (Reset),
    .Flush          (Flush),
    .InValid        (InValid),
    .InReady        (InReady),
    .InPC           (InPC),
    .InInstruction  (InInstruction),
    .OutValid       (OutValid),
    .OutReady       (OutReady),
    .OutPC          (OutPC),
    .OutInstruction (OutInstruction),
    .Count          (Count)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_model();
    logic [2*WIDTH-1:0] head;
    int unsigned n;
    n = mq.size();
    head = (n > 0) ? mq[0] : '0;
    chk("count",    64'(Count),          64'(n));
    chk("outvalid", 64'(OutValid),       64'(n != 0));
    chk("inready",  64'(InReady),        64'(n != DEPTH));
    chk("outpc",    64'(OutPC),          64'(head[2*WIDTH-1:WIDTH]));
    chk("outinstr", 64'(OutInstruction), 64'(head[WIDTH-1:0]));
  endtask

  // Apply one rising edge: update the model from the inputs presented,
  // then compare 1 time unit after the edge.
  task automatic step();
    bit fl, pu, po;
    fl = Flush;
    pu = InValid && (mq.size() < DEPTH) && !fl;
    po = OutReady && (mq.size() > 0) && !fl;
    @(posedge Clk);
    if (fl) begin
      mq.delete();
    end else begin
      if (po) void'(mq.pop_front());
      if (pu) mq.push_back({InPC, InInstruction});
    end
    last_push  = pu;
    last_flush = fl;
    #1;
    check_model();
  endtask

  task automatic push_pcs(input int unsigned first_pc, input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      InValid       = 1'b1;
      InPC          = WIDTH'(first_pc + i * PC_STEP);
      InInstruction = $urandom;
      step();
    end
    InValid = 1'b0;
  endtask

  initial begin
    // Reset, then idle
    repeat (2) @(posedge Clk);
    #1;
    check_model();
    Reset = 1'b0;
    step();
    chk("rst_instr", 64'(OutInstruction), 64'(NOP_INSTR));
    step();

    // Fill with decode stalled, then drain in order
    OutReady = 1'b0;
    push_pcs(0, DEPTH);
    chk("full_count", 64'(Count), 64'(DEPTH));
    chk("full_inready", 64'(InReady), 64'd0);
    OutReady = 1'b1;
    chk("head_pc0", 64'(OutPC), 64'd0);
    step();
    chk("ready_after_pop", 64'(InReady), 64'd1);
    chk("head_pc4", 64'(OutPC), 64'd4);
    repeat (DEPTH) step();
    OutReady = 1'b0;

    // Streaming across pointer wrap
    OutReady = 1'b1;
    for (int unsigned i = 0; i < 10; i++) begin
      InValid       = 1'b1;
      InPC          = WIDTH'(i * PC_STEP);
      InInstruction = $urandom;
      step();
      chk("stream_count", 64'(Count), 64'd1);
      chk("stream_pc", 64'(OutPC), 64'(i * PC_STEP));
    end
    InValid = 1'b0;
    step();
    OutReady = 1'b0;

    // Flush beats a simultaneous push
    push_pcs(32'h100, 3);
    Flush = 1'b1;
    InValid = 1'b1;
    InPC = 32'h40;
    InInstruction = 32'hDEADBEEF;
    OutReady = 1'b1;
    step();
    Flush = 1'b0;
    InValid = 1'b0;
    chk("flush_count", 64'(Count), 64'd0);
    chk("flush_valid", 64'(OutValid), 64'd0);
    step();
    OutReady = 1'b0;

    // Full with pop and push offered together: pop only
    push_pcs(32'h200, DEPTH);
    OutReady = 1'b1;
    InValid  = 1'b1;
    InPC     = 32'h300;
    InInstruction = $urandom;
    step();
    chk("full_pop_count", 64'(Count), 64'(DEPTH - 1));
    InValid  = 1'b0;
    OutReady = 1'b0;
    Flush = 1'b1;
    step();
    Flush = 1'b0;

    // Asynchronous reset in mid-cycle
    push_pcs(32'h400, 2);
    chk("pre_rst_count", 64'(Count), 64'd2);
    #2;
    Reset = 1'b1;
    mq.delete();
    #1;
    check_model();
    chk("async_count", 64'(Count), 64'd0);
    #1;
    Reset = 1'b0;
    step();

    // Randomized traffic against the model
    last_push = 1'b0;
    last_flush = 1'b0;
    for (int unsigned cyc = 0; cyc < 500; cyc++) begin
      // A stalled fetch holds its entry until accepted.
      if (!(InValid && !last_push && !last_flush)) begin
        InValid       = ($urandom_range(0, 99) < 65);
        InPC          = $urandom;
        InInstruction = $urandom;
      end
      OutReady = ($urandom_range(0, 99) < 55);
      Flush    = ($urandom_range(0, 99) < 4);
      step();
    end
    InValid = 1'b0;
    OutReady = 1'b0;
    Flush = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
